// File: rtl/i2c_codec_target.sv
// I2C target receiver for WM8731-style 3-byte register writes: decodes SCL/SDA,
// ACKs matching bytes by pulling SDA low and emits one strobe per completed word.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_I,
  output logic       I2C_SDAT_OE,
  output logic       wr_valid,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       busy,
  output logic       abort
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, B1, B1_ACK, B2, B2_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic                   in_word;
  logic [7:0]             byte_next;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] hi_byte;
  logic       ack_on;

  // NOTE: the synchroniser and history flops carry no reset on purpose: they just
  // track the wire, and resetting them could fabricate a START/STOP edge on release.
  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], I2C_SCLK};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], I2C_SDAT_I};
    scl_d    <= scl_s;
    sda_d    <= sda_s;
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign in_word   = (state == B1) || (state == B1_ACK) || (state == B2);
  assign byte_next = {shift_reg[6:0], sda_s};

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      hi_byte     <= '0;
      ack_on      <= 1'b0;
      I2C_SDAT_OE <= 1'b0;
      wr_valid    <= 1'b0;
      abort       <= 1'b0;
      busy        <= 1'b0;
      reg_addr    <= '0;
      reg_data    <= '0;
    end else begin
      wr_valid <= 1'b0;
      abort    <= 1'b0;
      // Bus conditions win over any scl edge seen in the same cycle.
      if (start_det) begin
        abort       <= in_word;
        state       <= ADDR;
        bit_cnt     <= '0;
        ack_on      <= 1'b0;
        I2C_SDAT_OE <= 1'b0;
        busy        <= 1'b1;
      end else if (stop_det) begin
        abort       <= in_word;
        state       <= IDLE;
        bit_cnt     <= '0;
        ack_on      <= 1'b0;
        I2C_SDAT_OE <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          ADDR, B1, B2: begin
            if (scl_rise) begin
              shift_reg <= byte_next;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (state)
                  ADDR: state <= (byte_next == {DEV_ADDR, 1'b0}) ? ADDR_ACK : IGNORE;
                  B1: begin
                    hi_byte <= byte_next;
                    state   <= B1_ACK;
                  end
                  default: begin
                    reg_addr <= hi_byte[7:1];
                    reg_data <= {hi_byte[0], byte_next};
                    wr_valid <= 1'b1;
                    state    <= B2_ACK;
                  end
                endcase
              end
            end
          end
          ADDR_ACK, B1_ACK, B2_ACK: begin
            // First fall opens the ACK slot, the second one closes it.
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on      <= 1'b1;
                I2C_SDAT_OE <= 1'b1;
              end else begin
                ack_on      <= 1'b0;
                I2C_SDAT_OE <= 1'b0;
                bit_cnt     <= '0;
                case (state)
                  ADDR_ACK: state <= B1;
                  B1_ACK:   state <= B2;
                  default:  state <= IGNORE;
                endcase
              end
            end
          end
          default: I2C_SDAT_OE <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: bit-banged I2C master with an open-drain
// SDA model and a scoreboard of expected register writes.
module tb_i2c_codec_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       oe, wr_valid, busy, abort;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int abort_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~oe;

  i2c_codec_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .I2C_SCLK(scl), .I2C_SDAT_I(sda_line),
    .I2C_SDAT_OE(oe), .wr_valid(wr_valid), .reg_addr(reg_addr),
    .reg_data(reg_data), .busy(busy), .abort(abort)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wait_clk(4); sda_m = b[7-i];
      wait_clk(4); scl = 1'b1;
      wait_clk(8); scl = 1'b0;
    end
  endtask

  task automatic ack_slot(output logic ack);
    wait_clk(4); sda_m = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); ack = ~sda_line;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    ack_slot(ack);
  endtask

  task automatic do_start();
    if (!scl) begin
      wait_clk(4); sda_m = 1'b1;
      wait_clk(4); scl = 1'b1;
    end
    wait_clk(8); sda_m = 1'b0;
    wait_clk(8); scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(4); sda_m = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(8); sda_m = 1'b1;
    wait_clk(8);
  endtask

  // Scoreboard side: every wr_valid must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && abort) abort_cnt++;
    if (!reset && wr_valid) begin
      wr_cnt++;
      if (exp_q.size() == 0) check("wr_valid_unexpected", 1, 0);
      else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("sb_reg_addr", reg_addr, e[15:9]);
        check("sb_reg_data", reg_data, e[8:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic a0, a1, a2, a3;
    int wr0, ab0;
    int oe_seen;

    wait_clk(5);
    check("rst_oe", oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_abort", abort, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_data", reg_data, 0);
    reset = 1'b0;
    wait_clk(10);

    // T1: basic write
    wr0 = wr_cnt; ab0 = abort_cnt;
    exp_q.push_back({7'h0F, 9'h000});
    do_start();
    check("t1_busy_start", busy, 1);
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    do_stop();
    check("t1_acks", {a0, a1, a2}, 3'b111);
    check("t1_wr_count", wr_cnt - wr0, 1);
    check("t1_reg_addr", reg_addr, 7'h0F);
    check("t1_reg_data", reg_data, 9'h000);
    check("t1_busy_stop", busy, 0);

    // T2: data bit 8 set
    wr0 = wr_cnt;
    exp_q.push_back({7'h07, 9'h180});
    do_start();
    check("t2_busy_start", busy, 1);
    send_byte(8'h34, a0); send_byte(8'h0F, a1); send_byte(8'h80, a2);
    do_stop();
    check("t2_acks", {a0, a1, a2}, 3'b111);
    check("t2_wr_count", wr_cnt - wr0, 1);
    check("t2_busy_stop", busy, 0);

    // T3: wrong address, whole transaction ignored
    wr0 = wr_cnt; ab0 = abort_cnt; oe_seen = 0;
    do_start();
    fork
      begin send_byte(8'h36, a0); send_byte(8'h12, a1); send_byte(8'h01, a2); end
      repeat (450) begin @(negedge clk); if (oe) oe_seen++; end
    join
    do_stop();
    check("t3_oe_never", oe_seen, 0);
    check("t3_wr_count", wr_cnt - wr0, 0);
    check("t3_abort_count", abort_cnt - ab0, 0);
    check("t3_reg_addr_held", reg_addr, 7'h07);
    check("t3_reg_data_held", reg_data, 9'h180);

    // T4: read address NACKed, then repeated start with a valid write
    wr0 = wr_cnt; ab0 = abort_cnt;
    do_start();
    send_byte(8'h35, a0);
    check("t4_read_nack", a0, 0);
    exp_q.push_back({7'h09, 9'h001});
    do_start();
    send_byte(8'h34, a0); send_byte(8'h12, a1); send_byte(8'h01, a2);
    do_stop();
    check("t4_acks", {a0, a1, a2}, 3'b111);
    check("t4_wr_count", wr_cnt - wr0, 1);
    check("t4_abort_count", abort_cnt - ab0, 0);

    // T5: STOP mid second data byte aborts the word
    wr0 = wr_cnt; ab0 = abort_cnt;
    do_start();
    send_byte(8'h34, a0); send_byte(8'h08, a1);
    send_bits(8'hF0, 4);
    do_stop();
    check("t5_abort_count", abort_cnt - ab0, 1);
    check("t5_wr_count", wr_cnt - wr0, 0);
    check("t5_reg_addr_held", reg_addr, 7'h09);
    check("t5_reg_data_held", reg_data, 9'h001);
    exp_q.push_back({7'h0F, 9'h000});
    do_start();
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2);
    do_stop();
    check("t5_t1_again_acks", {a0, a1, a2}, 3'b111);
    check("t5_t1_again_wr", wr_cnt - wr0, 1);

    // T6: extra byte NACKed, then reset during the B1 ACK slot
    wr0 = wr_cnt; ab0 = abort_cnt;
    exp_q.push_back({7'h0F, 9'h000});
    do_start();
    send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2); send_byte(8'hAA, a3);
    do_stop();
    check("t6_acks", {a0, a1, a2, a3}, 4'b1110);
    check("t6_wr_count", wr_cnt - wr0, 1);
    check("t6_abort_count", abort_cnt - ab0, 0);

    wr0 = wr_cnt; ab0 = abort_cnt;
    do_start();
    send_byte(8'h34, a0);
    send_bits(8'h1E, 8);
    for (int i = 0; i < 12 && !oe; i++) wait_clk(1);
    check("t6_oe_b1_ack", oe, 1);
    reset = 1'b1;
    wait_clk(1);
    check("t6_rst_oe", oe, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_reg_addr", reg_addr, 0);
    check("t6_rst_reg_data", reg_data, 0);
    reset = 1'b0;
    ack_slot(a1);
    check("t6_after_rst_nack", a1, 0);
    do_stop();
    check("t6_after_rst_busy", busy, 0);
    check("t6_after_rst_wr", wr_cnt - wr0, 0);
    check("t6_after_rst_abort", abort_cnt - ab0, 0);

    wait_clk(4);
    check("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
